// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions used by the host transmitter and the scancode receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        WAIT_IDLE
    } ps2_state_t;

    // start + 8 data + parity + stop
    localparam int PS2_FRAME_BITS = 11;

    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line plus a delayed copy for edge detection.
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic level,
    output logic fall,
    output logic rise
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    // Idle PS/2 lines float high, so reset to 1 to avoid a spurious edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
            prev_reg <= 1'b1;
        end else begin
            meta_reg <= line;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign level = sync_reg;
    assign fall  = prev_reg & ~sync_reg;
    assign rise  = ~prev_reg & sync_reg;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send, 11-bit shift on device clocks, ACK check.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_TIMEOUT  = 750000,
    parameter int FRAME_TIMEOUT  = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       kClock,
    input  logic       kData,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       kClock_drive_low,
    output logic       kData_drive_low,
    output logic       busy,
    output logic       done,
    output logic       nack,
    output logic       timeout
);

    localparam int TMO_MAX = (START_TIMEOUT > FRAME_TIMEOUT) ? START_TIMEOUT : FRAME_TIMEOUT;
    localparam int TMO_W   = $clog2(TMO_MAX + 1);
    localparam int INH_W   = $clog2(INHIBIT_CYCLES + 1);

    ps2_state_t       state_reg, state_next;
    logic [INH_W-1:0] inh_cnt_reg;
    logic [TMO_W-1:0] tmo_cnt_reg;
    logic [3:0]       bit_cnt_reg;
    logic [8:0]       shift_reg;
    logic             kdata_low_reg;
    logic             done_reg;
    logic             nack_reg;
    logic             timeout_reg;

    // Index 0 = kClock, index 1 = kData
    logic [1:0] raw_lines;
    logic [1:0] line_level;
    logic [1:0] line_fall;
    logic [1:0] line_rise;

    assign raw_lines = {kData, kClock};

    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        ps2_line_sync u_sync (
            .clk   (clk),
            .rst   (rst),
            .line  (raw_lines[gi]),
            .level (line_level[gi]),
            .fall  (line_fall[gi]),
            .rise  (line_rise[gi])
        );
    end

    logic unused_edges;
    assign unused_edges = &{1'b0, line_rise, line_fall[1]};

    logic clk_fall;
    logic lines_idle;
    logic tmo_expired;
    logic last_edge;

    assign clk_fall    = line_fall[0];
    assign lines_idle  = line_level[0] & line_level[1];
    assign tmo_expired = ((state_reg == SHIFT) || (state_reg == WAIT_IDLE)) && (tmo_cnt_reg == '0);
    assign last_edge   = clk_fall && (bit_cnt_reg == 4'(PS2_FRAME_BITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Expiry is checked before any clock edge so a simultaneous edge loses.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:      if (tx_start) state_next = INHIBIT;
            INHIBIT:   if (inh_cnt_reg == '0) state_next = REQ;
            REQ:       state_next = SHIFT;
            SHIFT: begin
                if (tmo_expired)    state_next = IDLE;
                else if (last_edge) state_next = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (tmo_expired)     state_next = IDLE;
                else if (lines_idle) state_next = IDLE;
            end
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inh_cnt_reg   <= '0;
            tmo_cnt_reg   <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            kdata_low_reg <= 1'b0;
            done_reg      <= 1'b0;
            nack_reg      <= 1'b0;
            timeout_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            unique case (state_reg)
                IDLE: begin
                    if (tx_start) begin
                        shift_reg   <= {odd_parity(tx_data), tx_data};
                        nack_reg    <= 1'b0;
                        timeout_reg <= 1'b0;
                        inh_cnt_reg <= INH_W'(INHIBIT_CYCLES - 1);
                    end
                end
                INHIBIT: begin
                    if (inh_cnt_reg != '0) inh_cnt_reg <= inh_cnt_reg - 1'b1;
                end
                REQ: begin
                    kdata_low_reg <= 1'b1;
                    bit_cnt_reg   <= '0;
                    tmo_cnt_reg   <= TMO_W'(START_TIMEOUT - 1);
                end
                SHIFT: begin
                    if (tmo_expired) begin
                        kdata_low_reg <= 1'b0;
                        timeout_reg   <= 1'b1;
                        done_reg      <= 1'b1;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg - 1'b1;
                        if (clk_fall) begin
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            if (bit_cnt_reg == 4'd0) tmo_cnt_reg <= TMO_W'(FRAME_TIMEOUT - 1);
                            // Stop bit shifts in behind parity, so edge 10 releases the line.
                            if (!last_edge) begin
                                kdata_low_reg <= ~shift_reg[0];
                                shift_reg     <= {1'b1, shift_reg[8:1]};
                            end else begin
                                nack_reg <= line_level[1];
                            end
                        end
                    end
                end
                WAIT_IDLE: begin
                    kdata_low_reg <= 1'b0;
                    if (tmo_expired) begin
                        timeout_reg <= 1'b1;
                        done_reg    <= 1'b1;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg - 1'b1;
                        if (lines_idle) done_reg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        kClock_drive_low = 1'b0;
        kData_drive_low  = 1'b0;
        unique case (state_reg)
            INHIBIT: kClock_drive_low = 1'b1;
            REQ: begin
                kClock_drive_low = 1'b1;
                kData_drive_low  = 1'b1;
            end
            SHIFT:   kData_drive_low = kdata_low_reg;
            default: ;
        endcase
    end

    assign busy    = (state_reg != IDLE);
    assign done    = done_reg;
    assign nack    = nack_reg;
    assign timeout = timeout_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple open-drain PS/2 device model clocking at 20 cycles.
module tb_ps2_host_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       dev_clk;
    logic       dev_data;
    logic       kClock_drive_low;
    logic       kData_drive_low;
    logic       busy;
    logic       done;
    logic       nack;
    logic       timeout;
    wire        kClock;
    wire        kData;

    int tests_run    = 0;
    int tests_failed = 0;

    // Open-drain lines with pull-ups: low if either side pulls low.
    assign kClock = kClock_drive_low ? 1'b0 : dev_clk;
    assign kData  = kData_drive_low  ? 1'b0 : dev_data;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (8),
        .START_TIMEOUT  (50),
        .FRAME_TIMEOUT  (400)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .kClock           (kClock),
        .kData            (kData),
        .tx_data          (tx_data),
        .tx_start         (tx_start),
        .kClock_drive_low (kClock_drive_low),
        .kData_drive_low  (kData_drive_low),
        .busy             (busy),
        .done             (done),
        .nack             (nack),
        .timeout          (timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Accept a byte, then measure the inhibit and request phases.
    task automatic start_frame(input logic [7:0] d, input string tag);
        int inh = 0;
        int req = 0;
        tx_data  = d;
        tx_start = 1'b1;
        tick(1);
        tx_start = 1'b0;
        check({tag, "_busy_on_accept"}, busy, 1);
        check({tag, "_nack_cleared"}, nack, 0);
        check({tag, "_timeout_cleared"}, timeout, 0);
        while (kClock_drive_low && !kData_drive_low && inh < 100) begin
            inh++;
            tick(1);
        end
        check({tag, "_inhibit_len"}, inh, 8);
        while (kClock_drive_low && kData_drive_low && req < 100) begin
            req++;
            tick(1);
        end
        check({tag, "_req_len"}, req, 1);
        check({tag, "_start_bit_held"}, {kClock_drive_low, kData_drive_low}, 2'b01);
    endtask

    // Device side: 11 clocks, samples data on rising edges, optional ACK and disturbances.
    task automatic device_frame(input int ack_en, input int ack_extra, input int stray_at,
                                input int abort_at, output logic [10:0] bits, output bit aborted);
        int n = 0;
        bits    = '1;
        aborted = 1'b0;
        while (!(kClock == 1'b1 && kData == 1'b0) && n < 100) begin
            tick(1);
            n++;
        end
        check("dev_saw_request", (n < 100), 1);
        tick(5);
        bits[0] = kData;
        for (int k = 1; k <= 11; k++) begin
            dev_clk = 1'b0;
            if (k == abort_at) begin
                tick(4);
                rst = 1'b1;
                tick(1);
                check("abort_drives_released", {kClock_drive_low, kData_drive_low}, 2'b00);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                rst      = 1'b0;
                dev_clk  = 1'b1;
                dev_data = 1'b1;
                aborted  = 1'b1;
                return;
            end
            if (k == stray_at) begin
                tick(2);
                tx_data  = 8'h00;
                tx_start = 1'b1;
                tick(1);
                tx_start = 1'b0;
                tick(7);
            end else begin
                tick(10);
            end
            dev_clk = 1'b1;
            if (k <= 10) bits[k] = kData;
            if (k == 10 && ack_en != 0) dev_data = 1'b0;
            if (k == 11) begin
                if (ack_extra > 0) begin
                    tick(ack_extra);
                    check("ack_hold_still_busy", busy, 1);
                end
                dev_data = 1'b1;
            end else begin
                tick(10);
            end
        end
    endtask

    task automatic wait_done(input string tag, output int cycles);
        cycles = 0;
        while (!done && cycles < 1000) begin
            tick(1);
            cycles++;
        end
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_busy_with_done"}, busy, 0);
        check({tag, "_drives_idle"}, {kClock_drive_low, kData_drive_low}, 2'b00);
    endtask

    task automatic check_pulse_end(input string tag);
        tick(1);
        check({tag, "_done_one_cycle"}, done, 0);
    endtask

    task automatic check_bits(input string tag, input logic [10:0] bits,
                              input logic [7:0] exp_data, input logic exp_par);
        check({tag, "_start"}, bits[0], 0);
        check({tag, "_data"}, bits[8:1], exp_data);
        check({tag, "_parity"}, bits[9], exp_par);
        check({tag, "_stop"}, bits[10], 1);
        $display("[TB] frame %s data=0x%02h parity=%0b stop=%0b nack=%0b timeout=%0b",
                 tag, bits[8:1], bits[9], bits[10], nack, timeout);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] bits;
        bit          ab;
        int          cyc;
        int          seen;

        rst      = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        tick(3);
        check("rst_kclock_drive", kClock_drive_low, 0);
        check("rst_kdata_drive", kData_drive_low, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_nack", nack, 0);
        check("rst_timeout", timeout, 0);
        rst = 1'b0;
        tick(2);

        // 1: LED command, normal ACK
        start_frame(8'hED, "t1");
        device_frame(1, 0, 0, 0, bits, ab);
        wait_done("t1", cyc);
        check("t1_nack", nack, 0);
        check("t1_timeout", timeout, 0);
        check_bits("t1", bits, 8'hED, 1'b1);
        check_pulse_end("t1");

        // 2: reset command, device withholds ACK
        start_frame(8'hFF, "t2");
        device_frame(0, 0, 0, 0, bits, ab);
        wait_done("t2", cyc);
        check("t2_nack", nack, 1);
        check("t2_timeout", timeout, 0);
        check_bits("t2", bits, 8'hFF, 1'b1);
        check_pulse_end("t2");

        // 3: device never clocks
        start_frame(8'h5A, "t3");
        wait_done("t3", cyc);
        check("t3_timeout_cycles", cyc, 50);
        check("t3_timeout", timeout, 1);
        check("t3_nack", nack, 0);
        $display("[TB] frame t3 timeout after %0d cycles timeout=%0b", cyc, timeout);
        check_pulse_end("t3");

        // 4: stray start while busy is ignored
        start_frame(8'hA5, "t4");
        device_frame(1, 0, 3, 0, bits, ab);
        wait_done("t4", cyc);
        check("t4_nack", nack, 0);
        check("t4_timeout", timeout, 0);
        check_bits("t4", bits, 8'hA5, 1'b1);
        tick(3);
        check("t4_no_queued_frame", busy, 0);

        // 5: reset mid-frame, then a clean frame
        start_frame(8'h3C, "t5a");
        device_frame(1, 0, 0, 5, bits, ab);
        check("t5_aborted", ab, 1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            seen = seen | int'(done) | int'(busy);
        end
        check("t5_quiet_after_reset", seen, 0);
        $display("[TB] frame t5a aborted by reset at edge 5");
        start_frame(8'hF4, "t5b");
        device_frame(1, 0, 0, 0, bits, ab);
        wait_done("t5b", cyc);
        check("t5b_nack", nack, 0);
        check_bits("t5b", bits, 8'hF4, 1'b0);
        check_pulse_end("t5b");

        // 6: ACK released late; done waits for kData high
        start_frame(8'h00, "t6");
        device_frame(1, 8, 0, 0, bits, ab);
        wait_done("t6", cyc);
        check("t6_done_soon_after_release", (cyc <= 6), 1);
        check("t6_nack", nack, 0);
        check("t6_timeout", timeout, 0);
        check_bits("t6", bits, 8'h00, 1'b1);
        check_pulse_end("t6");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
